adder_sum_accumulator: RTL and testbench
========================================

Name: adder_sum_accumulator

Overview:
Downstream consumer of the registered adder. Takes the adder's W+1-bit sum and isOdd flag as a valid/ready stream and reduces a programmable-length batch of results. Per batch it produces the running total, the number of odd results and the maximum sum. The result is held on a valid/ready output port until taken.

Parameters:
W, 8, adder operand width; input sum is W+1 bits.
N_MAX, 16, maximum batch length (power of two, ≥2).
Derived localparams: CNT_W = $clog2(N_MAX)+1; ACC_W = W+1+$clog2(N_MAX).

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request new batch; sampled only in IDLE
batch_len  in  CNT_W  samples in batch, 1..N_MAX; sampled with start
in_valid  in  1  adder result present
in_sum  in  W+1  adder sum (unsigned)
in_is_odd  in  1  adder isOdd flag
in_ready  out  1  accumulator accepts a sample this cycle
busy  out  1  high in ACCUM or DONE
out_valid  out  1  batch result present
out_ready  in  1  consumer takes result
out_total  out  ACC_W  sum of all batch samples, zero-extended, never overflows
out_odd_count  out  CNT_W  count of samples with in_is_odd=1
out_max  out  W+1  largest in_sum in batch
err  out  1  sticky parity mismatch (see Optional Feature)

Behaviour:
- Reset: state=IDLE. in_ready, busy, out_valid, err = 0. out_total, out_odd_count, out_max, remaining counter = 0.
- IDLE:
  - in_ready=0.
  - start=1 with batch_len in 1..N_MAX: clear total/odd/max, load remaining=batch_len, go to ACCUM next cycle.
  - start with batch_len=0 or >N_MAX: ignored, stay IDLE.
- ACCUM:
  - in_ready=1.
  - A transfer occurs when in_valid&in_ready: total += in_sum; odd += in_is_odd; max = max(max, in_sum); remaining -= 1.
  - Transfer with remaining==1: go to DONE. out_valid rises the cycle after the last transfer (1-cycle latency). in_ready drops in that same cycle.
  - Cycles with in_valid=0 change nothing.
  - start is ignored.
- DONE:
  - out_valid=1. out_* hold stable. in_ready=0.
  - out_ready=1: out_valid=0 next cycle, go to IDLE. Outputs keep their last values until the next start.
  - start is ignored.
  - A back-to-back batch is possible: start in the cycle after the handshake, so the result-to-next-start gap is 1 cycle minimum.
- Arithmetic: unsigned, in_sum zero-extended to ACC_W. A maximum input of 2^(W+1)-1 for N_MAX samples fits exactly in ACC_W.
- Max tie: equal values leave max unchanged.
- Reset mid-batch or mid-DONE: asynchronous clear, partial results discarded, out_valid drops immediately.
- Outputs are registered. No combinational path from in_valid or out_ready to any output.

Optional Feature:
- Macro ADDER_ACC_PARITY_CHECK_EN.
- Defined: on every transfer, compare in_is_odd against in_sum[0]. A mismatch sets err=1. err is sticky until reset. Accumulation still uses in_is_odd as given.
- Undefined: err is tied to 0 and no compare logic is built.

Decomposition:
- Shared package adder_pkg: default W, N_MAX, state enum {IDLE, ACCUM, DONE}, width helper functions for CNT_W/ACC_W.
- One natural sub-module, adder_acc_datapath: holds the total/odd/max registers with clear and update enables. The FSM and remaining counter live in the top.

Test Plan:
1. Reset, then start batch_len=4, feed sums 2,11,4,6 (isOdd 0,1,0,0) one per cycle. Result: out_total=23, out_odd_count=1, out_max=11. out_valid rises 1 cycle after the 4th transfer.
2. batch_len=3, feed 9,3,7 with in_valid gaps of 2 cycles between samples. Result: total=19, odd=3, max=9; no extra counts during gaps.
3. Hold out_ready=0 for 5 cycles in DONE while pulsing start and in_valid. Outputs stay stable, in_ready stays 0. Then out_ready=1: out_valid=0 next cycle, state IDLE.
4. batch_len=N_MAX=16, all sums 511 (W=8). Result: out_total=8176, no overflow, out_max=511, odd_count=16.
5. start with batch_len=0 → stays IDLE, busy=0. Assert reset after 2 of 4 samples in a batch → all outputs 0 immediately; a new batch of 1,1 then gives total=2.
6. With ADDER_ACC_PARITY_CHECK_EN, send in_sum=6 with in_is_odd=1 → err=1, stays set through subsequent batches until reset. Without the macro, err remains 0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder result accumulator.
// Default widths, the controller state encoding and helpers for derived widths.
package adder_pkg;

  localparam int W_DEF     = 8;
  localparam int N_MAX_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of the remaining/odd counters: must hold the value N_MAX itself.
  function automatic int cnt_w(input int n_max);
    return $clog2(n_max) + 1;
  endfunction

  // Width of the running total: N_MAX full-scale sums fit without overflow.
  function automatic int acc_w(input int w, input int n_max);
    return w + 1 + $clog2(n_max);
  endfunction

endpackage

// File: rtl/adder_acc_datapath.sv
// Batch reduction registers: running total, odd-sample count and maximum sum.
// The clear and update enables come from the controller in the top.
module adder_acc_datapath #(
  parameter int W     = 8,
  parameter int CNT_W = 5,
  parameter int ACC_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             upd,
  input  logic [W:0]       in_sum,
  input  logic             in_is_odd,
  output logic [ACC_W-1:0] total,
  output logic [CNT_W-1:0] odd_count,
  output logic [W:0]       max_val
);

  // Clear at batch start, fold one sample into the reduction on each transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total     <= '0;
      odd_count <= '0;
      max_val   <= '0;
    end else if (clr) begin
      total     <= '0;
      odd_count <= '0;
      max_val   <= '0;
    end else if (upd) begin
      total     <= total + ACC_W'(in_sum);
      odd_count <= odd_count + CNT_W'(in_is_odd);
      // Strictly greater: a tie leaves the stored maximum untouched.
      if (in_sum > max_val) begin
        max_val <= in_sum;
      end
    end
  end

endmodule

// File: rtl/adder_sum_accumulator.sv
// Accumulates a programmable-length batch of adder results (sum, isOdd)
// and presents total / odd count / max on a valid-ready output port.
// Optional build macro: ADDER_ACC_PARITY_CHECK_EN enables a sticky err flag
// raised when in_is_odd disagrees with in_sum[0] on any transfer.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start with a legal batch_len; outputs hold
//   ACCUM | in_ready=1, each in_valid cycle folds one sample in
//   DONE  | out_valid=1, result held until out_ready
module adder_sum_accumulator
  import adder_pkg::*;
#(
  parameter  int W     = W_DEF,
  parameter  int N_MAX = N_MAX_DEF,
  localparam int CNT_W = cnt_w(N_MAX),
  localparam int ACC_W = acc_w(W, N_MAX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] batch_len,
  input  logic             in_valid,
  input  logic [W:0]       in_sum,
  input  logic             in_is_odd,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [CNT_W-1:0] out_odd_count,
  output logic [W:0]       out_max,
  output logic             err
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(N_MAX);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             xfer;
  logic             start_ok;
  logic             clr;

  // in_ready is a register that is high exactly in ACCUM, so a transfer
  // can only happen while accumulating.
  assign xfer     = in_valid & in_ready;
  assign start_ok = start && (batch_len != '0) && (batch_len <= LEN_MAX);
  assign clr      = (state == IDLE) && start_ok;

  // Batch controller: state, remaining down-counter and registered handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            remaining <= batch_len;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (xfer) begin
            remaining <= remaining - ONE;
            if (remaining == ONE) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          remaining <= '0;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  adder_acc_datapath #(
    .W     (W),
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .upd       (xfer),
    .in_sum    (in_sum),
    .in_is_odd (in_is_odd),
    .total     (out_total),
    .odd_count (out_odd_count),
    .max_val   (out_max)
  );

`ifdef ADDER_ACC_PARITY_CHECK_EN
  // Sticky flag: any transfer whose isOdd disagrees with the sum LSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (xfer && (in_is_odd != in_sum[0])) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Self-checking bench for adder_sum_accumulator (W=8, N_MAX=16).
module tb_adder_sum_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  batch_len;
  logic        in_valid;
  logic [8:0]  in_sum;
  logic        in_is_odd;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_total;
  logic [4:0]  out_odd_count;
  logic [8:0]  out_max;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

`ifdef ADDER_ACC_PARITY_CHECK_EN
  localparam int PARITY_EN = 1;
`else
  localparam int PARITY_EN = 0;
`endif

  typedef struct packed {
    logic [4:0]       len;
    logic [15:0][8:0] sums;
    logic [15:0]      odds;
    logic [1:0]       gap;
    logic [15:0]      e_total;
    logic [7:0]       e_odd;
    logic [8:0]       e_max;
  } vec_t;

  vec_t vecs[5];

  adder_sum_accumulator #(.W(8), .N_MAX(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .batch_len     (batch_len),
    .in_valid      (in_valid),
    .in_sum        (in_sum),
    .in_is_odd     (in_is_odd),
    .in_ready      (in_ready),
    .busy          (busy),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_total     (out_total),
    .out_odd_count (out_odd_count),
    .out_max       (out_max),
    .err           (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start a batch, feed it with optional idle gaps carrying junk data,
  // check the result and complete the output handshake.
  task automatic run_batch(input string tag, input int len, input logic [15:0][8:0] sums,
                           input logic [15:0] odds, input int gap,
                           input int e_total, input int e_odd, input int e_max);
    start = 1'b1;
    batch_len = 5'(len);
    tick();
    start = 1'b0;
    check({tag, "_busy"}, int'(busy), 1);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid  = 1'b0;
          in_sum    = 9'($urandom);
          in_is_odd = 1'($urandom);
          tick();
        end
      end
      in_valid  = 1'b1;
      in_sum    = sums[i];
      in_is_odd = odds[i];
      if (i == len - 1) check({tag, "_early_valid"}, int'(out_valid), 0);
      tick();
    end
    in_valid = 1'b0;
    check({tag, "_out_valid"}, int'(out_valid), 1);
    check({tag, "_in_ready_done"}, int'(in_ready), 0);
    check({tag, "_total"}, int'(out_total), e_total);
    check({tag, "_odd"}, int'(out_odd_count), e_odd);
    check({tag, "_max"}, int'(out_max), e_max);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, int'(out_valid), 0);
    check({tag, "_idle_busy"}, int'(busy), 0);
    check({tag, "_total_held"}, int'(out_total), e_total);
  endtask

  initial begin
    logic [15:0][8:0] s;
    logic [15:0]      o;
    int               len, tot, odd, mx, gap;

    reset = 1'b1; start = 1'b0; batch_len = '0; in_valid = 1'b0;
    in_sum = '0; in_is_odd = 1'b0; out_ready = 1'b0;

    vecs[0] = '0;
    vecs[0].len = 5'd4; vecs[0].gap = 2'd0;
    vecs[0].sums[0] = 9'd2; vecs[0].sums[1] = 9'd11; vecs[0].sums[2] = 9'd4; vecs[0].sums[3] = 9'd6;
    vecs[0].odds = 16'b0010;
    vecs[0].e_total = 16'd23; vecs[0].e_odd = 8'd1; vecs[0].e_max = 9'd11;

    vecs[1] = '0;
    vecs[1].len = 5'd3; vecs[1].gap = 2'd2;
    vecs[1].sums[0] = 9'd9; vecs[1].sums[1] = 9'd3; vecs[1].sums[2] = 9'd7;
    vecs[1].odds = 16'b0111;
    vecs[1].e_total = 16'd19; vecs[1].e_odd = 8'd3; vecs[1].e_max = 9'd9;

    vecs[2] = '0;
    vecs[2].len = 5'd16; vecs[2].gap = 2'd0;
    for (int i = 0; i < 16; i++) vecs[2].sums[i] = 9'd511;
    vecs[2].odds = 16'hFFFF;
    vecs[2].e_total = 16'd8176; vecs[2].e_odd = 8'd16; vecs[2].e_max = 9'd511;

    vecs[3] = '0;
    vecs[3].len = 5'd1; vecs[3].gap = 2'd0;
    vecs[3].sums[0] = 9'd5; vecs[3].odds = 16'b1;
    vecs[3].e_total = 16'd5; vecs[3].e_odd = 8'd1; vecs[3].e_max = 9'd5;

    vecs[4] = '0;
    vecs[4].len = 5'd3; vecs[4].gap = 2'd1;
    vecs[4].sums[0] = 9'd7; vecs[4].sums[1] = 9'd7; vecs[4].sums[2] = 9'd3;
    vecs[4].odds = 16'b0111;
    vecs[4].e_total = 16'd17; vecs[4].e_odd = 8'd3; vecs[4].e_max = 9'd7;

    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_total", int'(out_total), 0);
    check("rst_odd", int'(out_odd_count), 0);
    check("rst_max", int'(out_max), 0);

    // Table vectors, back to back: next start right after each handshake.
    for (int v = 0; v < 5; v++) begin
      run_batch($sformatf("vec%0d", v), int'(vecs[v].len), vecs[v].sums, vecs[v].odds,
                int'(vecs[v].gap), int'(vecs[v].e_total), int'(vecs[v].e_odd), int'(vecs[v].e_max));
    end

    // Result held in DONE while start and in_valid are pulsed.
    start = 1'b1; batch_len = 5'd2; tick(); start = 1'b0;
    in_valid = 1'b1; in_sum = 9'd100; in_is_odd = 1'b0; tick();
    in_sum = 9'd50; tick();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      start = c[0]; batch_len = 5'd3;
      in_valid = ~c[0]; in_sum = 9'd511; in_is_odd = 1'b1;
      tick();
      check("hold_valid", int'(out_valid), 1);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_total", int'(out_total), 150);
      check("hold_odd", int'(out_odd_count), 0);
      check("hold_max", int'(out_max), 100);
    end
    start = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("hold_release_valid", int'(out_valid), 0);
    check("hold_release_busy", int'(busy), 0);
    tick();
    check("hold_idle_in_ready", int'(in_ready), 0);

    // Illegal batch lengths are ignored.
    start = 1'b1; batch_len = 5'd0; tick();
    check("len0_busy", int'(busy), 0);
    batch_len = 5'd17; tick();
    check("len17_busy", int'(busy), 0);
    check("len17_in_ready", int'(in_ready), 0);
    start = 1'b0;

    // Asynchronous reset two samples into a four-sample batch.
    start = 1'b1; batch_len = 5'd4; tick(); start = 1'b0;
    in_valid = 1'b1; in_sum = 9'd40; in_is_odd = 1'b0; tick();
    in_sum = 9'd60; tick();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrst_total", int'(out_total), 0);
    check("midrst_max", int'(out_max), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    #2 reset = 1'b0;
    tick();
    s = '0; s[0] = 9'd1; s[1] = 9'd1;
    run_batch("after_rst", 2, s, 16'b11, 0, 2, 2, 1);

    // Reset while a result is waiting in DONE.
    start = 1'b1; batch_len = 5'd1; tick(); start = 1'b0;
    in_valid = 1'b1; in_sum = 9'd8; in_is_odd = 1'b0; tick(); in_valid = 1'b0;
    check("done_pre_valid", int'(out_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("done_rst_valid", int'(out_valid), 0);
    check("done_rst_total", int'(out_total), 0);
    #2 reset = 1'b0;
    tick();

    // Parity mismatch: in_is_odd=1 with an even sum.
    s = '0; s[0] = 9'd6;
    run_batch("parity", 1, s, 16'b1, 0, 6, 1, 6);
    check("parity_err", int'(err), PARITY_EN);
    s = '0; s[0] = 9'd4; s[1] = 9'd3;
    run_batch("parity_next", 2, s, 16'b10, 0, 7, 1, 4);
    check("parity_err_sticky", int'(err), PARITY_EN);
    reset = 1'b1; tick(); reset = 1'b0; tick();
    check("parity_err_cleared", int'(err), 0);

    // Randomized batches against a plain arithmetic reference.
    for (int b = 0; b < 25; b++) begin
      len = $urandom_range(1, 16);
      gap = $urandom_range(0, 2);
      s = '0; o = '0;
      tot = 0; odd = 0; mx = 0;
      for (int i = 0; i < len; i++) begin
        s[i] = 9'($urandom_range(0, 511));
        o[i] = s[i][0];
        tot += int'(s[i]);
        if (o[i]) odd++;
        if (int'(s[i]) > mx) mx = int'(s[i]);
      end
      run_batch($sformatf("rand%0d", b), len, s, o, gap, tot, odd, mx);
    end
    check("rand_err", int'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
